// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - CSA key schedule constants, key-bit permutation and bank FSM states
package csa_pkg;

  localparam int CSA_KK_ROUNDS = 7;
  localparam int CK_W          = 64;
  localparam int KK_W          = 448;

  // Destination position of each source key bit, both counted MSB-first
  // (position 0 is bit 63, i.e. the MSB of the first CK byte).
  localparam logic [5:0] KEY_PERM [64] = '{
    6'd17, 6'd35, 6'd8,  6'd6,  6'd41, 6'd48, 6'd28, 6'd20,
    6'd27, 6'd53, 6'd61, 6'd49, 6'd18, 6'd32, 6'd58, 6'd63,
    6'd23, 6'd19, 6'd36, 6'd38, 6'd1,  6'd52, 6'd26, 6'd0,
    6'd33, 6'd3,  6'd12, 6'd13, 6'd56, 6'd39, 6'd25, 6'd40,
    6'd50, 6'd34, 6'd51, 6'd11, 6'd21, 6'd47, 6'd29, 6'd57,
    6'd44, 6'd30, 6'd7,  6'd24, 6'd22, 6'd46, 6'd60, 6'd16,
    6'd59, 6'd4,  6'd55, 6'd42, 6'd10, 6'd5,  6'd9,  6'd43,
    6'd31, 6'd62, 6'd45, 6'd14, 6'd2,  6'd37, 6'd15, 6'd54
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } bank_state_e;

  // Moves every key bit to its permuted position; ~p maps MSB-first p to a bit index.
  function automatic logic [CK_W-1:0] csa_key_perm(input logic [CK_W-1:0] k);
    logic [CK_W-1:0] p;
    p = '0;
    for (int i = 0; i < CK_W; i++) begin
      p[~KEY_PERM[i]] = k[~6'(i)];
    end
    return p;
  endfunction

endpackage

// File: rtl/csa_key_round.sv
// rtl/csa_key_round.sv - one key schedule step: round KK word and next permuted key
module csa_key_round
  import csa_pkg::*;
(
  input  logic [CK_W-1:0] kb,
  input  logic [2:0]      rnd,
  output logic [CK_W-1:0] kk_word,
  output logic [CK_W-1:0] kb_next
);

  // Round word is the current key with the round index folded into every byte.
  always_comb begin
    kk_word = kb ^ {8{{5'b0, rnd}}};
    kb_next = csa_key_perm(kb);
  end

endmodule

// File: rtl/csa_key_bank.sv
// rtl/csa_key_bank.sv - multi-channel CSA key expander with even/odd schedule bank
module csa_key_bank
  import csa_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [63:0]     i_ck,
  input  logic [CHW-1:0]  i_chan,
  input  logic            i_parity,
  input  logic            i_inv,
  input  logic [CHW-1:0]  i_inv_chan,
  input  logic            i_inv_parity,
  output logic            busy,
  output logic            done,
  output logic            drop,
  input  logic [CHW-1:0]  rd_chan,
  input  logic            rd_parity,
  output logic [447:0]    o_kk,
  output logic            o_valid
);

  localparam int SLOTS = CHANNELS * 2;
  localparam int SW    = CHW + 1;

  bank_state_e     state;
  bank_state_e     state_nx;

  logic [CK_W-1:0] kb;
  logic [CK_W-1:0] kk_word;
  logic [CK_W-1:0] kb_next;
  logic [2:0]      rnd;
  logic [SW-1:0]   tgt_slot;
  logic [KK_W-1:0] shadow;
  logic [KK_W-1:0] bank [SLOTS];
  logic [SLOTS-1:0] slot_valid;
  logic            drop_q;

  logic            start_ok;
  logic            start_drop;
  logic            chan_ok;
  logic            inv_ok;
  logic            rd_ok;
  logic [SW-1:0]   inv_slot;
  logic [SW-1:0]   rd_slot;

  // Channel indices above CHANNELS-1 exist only when CHANNELS is not a power of two.
  assign chan_ok  = 32'(i_chan) < CHANNELS;
  assign inv_ok   = i_inv && (32'(i_inv_chan) < CHANNELS);
  assign rd_ok    = 32'(rd_chan) < CHANNELS;
  assign inv_slot = {i_inv_chan, i_inv_parity};
  assign rd_slot  = {rd_chan, rd_parity};

  assign busy = (state != IDLE);
  assign done = (state == WRITE);
  assign drop = drop_q;

  csa_key_round u_round (
    .kb      (kb),
    .rnd     (rnd),
    .kk_word (kk_word),
    .kb_next (kb_next)
  );

  // Next-state logic; a start is only taken in IDLE and for an existing channel.
  always_comb begin
    state_nx   = state;
    start_ok   = 1'b0;
    start_drop = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (chan_ok) begin
            start_ok = 1'b1;
            state_nx = RUN;
          end else begin
            start_drop = 1'b1;
          end
        end
      end
      RUN: begin
        start_drop = start;
        if (rnd == 3'd0) begin
          state_nx = WRITE;
        end
      end
      WRITE: begin
        start_drop = start;
        state_nx   = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register; reset abandons any expansion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Expansion datapath: load CK at round 6, then one round into the shadow per cycle.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      kb       <= i_ck;
      rnd      <= 3'(CSA_KK_ROUNDS - 1);
      tgt_slot <= {i_chan, i_parity};
    end else if (state == RUN) begin
      shadow[{rnd, 6'd0} +: CK_W] <= kk_word;
      kb                          <= kb_next;
      rnd                         <= rnd - 3'd1;
    end
  end

  // Ignored-start indication, one cycle after the rejected request.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= start_drop;
    end
  end

  // Valid bits: invalidate first so a same-cycle write of the slot wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
    end else begin
      if (inv_ok) begin
        slot_valid[inv_slot] <= 1'b0;
      end
      if (state == WRITE) begin
        slot_valid[tgt_slot] <= 1'b1;
      end
    end
  end

  // Bank write port: the completed shadow lands in the target slot.
  always_ff @(posedge clk) begin
    if (!rst && state == WRITE) begin
      bank[tgt_slot] <= shadow;
    end
  end

  // Registered read port, no bypass of a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_kk    <= '0;
      o_valid <= 1'b0;
    end else if (rd_ok) begin
      o_kk    <= bank[rd_slot];
      o_valid <= slot_valid[rd_slot];
    end else begin
      o_kk    <= '0;
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csa_key_bank.sv
// tb/tb_csa_key_bank.sv - randomized self-checking bench for csa_key_bank
module tb_csa_key_bank;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [63:0]  i_ck;
  logic [1:0]   i_chan;
  logic         i_parity;
  logic         i_inv;
  logic [1:0]   i_inv_chan;
  logic         i_inv_parity;
  logic [1:0]   rd_chan;
  logic         rd_parity;
  logic         busy, done, drop, o_valid;
  logic [447:0] o_kk;
  logic         busy3, done3, drop3, o_valid3;
  logic [447:0] o_kk3;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [447:0] mdl_kk [8];
  bit           mdl_valid [8];

  int perm_tbl [64] = '{
    18, 36,  9,  7, 42, 49, 29, 21, 28, 54, 62, 50, 19, 33, 59, 64,
    24, 20, 37, 39,  2, 53, 27,  1, 34,  4, 13, 14, 57, 40, 26, 41,
    51, 35, 52, 12, 22, 48, 30, 58, 45, 31,  8, 25, 23, 47, 61, 17,
    60,  5, 56, 43, 11,  6, 10, 44, 32, 63, 46, 15,  3, 38, 16, 55
  };

  always #5 clk = ~clk;

  csa_key_bank #(.CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .i_ck(i_ck), .i_chan(i_chan),
    .i_parity(i_parity), .i_inv(i_inv), .i_inv_chan(i_inv_chan),
    .i_inv_parity(i_inv_parity), .busy(busy), .done(done), .drop(drop),
    .rd_chan(rd_chan), .rd_parity(rd_parity), .o_kk(o_kk), .o_valid(o_valid)
  );

  csa_key_bank #(.CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .i_ck(i_ck), .i_chan(i_chan),
    .i_parity(i_parity), .i_inv(i_inv), .i_inv_chan(i_inv_chan),
    .i_inv_parity(i_inv_parity), .busy(busy3), .done(done3), .drop(drop3),
    .rd_chan(rd_chan), .rd_parity(rd_parity), .o_kk(o_kk3), .o_valid(o_valid3)
  );

  // Source bit i (MSB-first, 1-based table) lands at MSB-first position tbl[i].
  function automatic logic [63:0] ref_perm(input logic [63:0] k);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      if (k[63 - i]) o = o | (64'h8000000000000000 >> (perm_tbl[i] - 1));
    end
    return o;
  endfunction

  function automatic logic [447:0] ref_kk(input logic [63:0] ck);
    logic [63:0]  kb;
    logic [447:0] kk;
    logic [7:0]   rb;
    kb = ck;
    kk = '0;
    for (int r = 6; r >= 0; r--) begin
      rb = 8'(r);
      kk[r*64 +: 64] = kb ^ {8{rb}};
      kb = ref_perm(kb);
    end
    return kk;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_slot(input int ch, input bit par, output logic v, output logic [447:0] kk);
    rd_chan   = 2'(ch);
    rd_parity = par;
    tick();
    v  = o_valid;
    kk = o_kk;
  endtask

  // Full load from start to read-ready; inv_k names the cycle (1..8) to invalidate the target.
  task automatic run_load(input logic [63:0] ck, input int ch, input bit par, input int inv_k,
                          output int nbusy, output int ndone, output int done_at, output int ndrop,
                          output logic old_v, output logic [447:0] old_kk);
    int slot;
    slot = ch * 2 + int'(par);
    nbusy = 0; ndone = 0; done_at = -1; ndrop = 0;
    rd_chan = 2'(ch); rd_parity = par;
    i_ck = ck; i_chan = 2'(ch); i_parity = par; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (busy) nbusy++;
      if (done) begin ndone++; done_at = k; end
      if (drop) ndrop++;
      if (k == 8) begin old_v = o_valid; old_kk = o_kk; end
      i_inv = (k == inv_k);
      i_inv_chan = 2'(ch); i_inv_parity = par;
      if (k == inv_k) mdl_valid[slot] = 1'b0;
      tick();
    end
    i_inv = 1'b0;
    mdl_kk[slot] = ref_kk(ck);
    mdl_valid[slot] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int s = 0; s < 8; s++) mdl_valid[s] = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", drop); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_kk !== 448'd0) begin n_fail++; $display("FAIL reset_kk: got %h want 0", o_kk); end
  endtask

  task automatic test_zero_key();
    int nb, nd, da, ndr;
    logic ov, v;
    logic [447:0] okk, kk;
    logic [7:0] rb;
    run_load(64'h0, 0, 1'b0, 0, nb, nd, da, ndr, ov, okk);
    n_cmp++; if (nb != 8) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 8", nb); end
    n_cmp++; if (nd != 1 || da != 8) begin n_fail++; $display("FAIL zero_done: got %0d pulses at %0d want 1 at 8", nd, da); end
    n_cmp++; if (ndr != 0) begin n_fail++; $display("FAIL zero_drop: got %0d want 0", ndr); end
    read_slot(0, 1'b0, v, kk);
    n_cmp++; if (v !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %b want 1", v); end
    for (int r = 0; r < 7; r++) begin
      rb = 8'(r);
      n_cmp++;
      if (kk[r*64 +: 64] !== {8{rb}}) begin
        n_fail++; $display("FAIL zero_round%0d: got %h want %h", r, kk[r*64 +: 64], {8{rb}});
      end
    end
  endtask

  task automatic test_known_key();
    int nb, nd, da, ndr;
    logic ov, v;
    logic [447:0] okk, kk;
    run_load(64'haf361916fd4b4b77, 2, 1'b1, 0, nb, nd, da, ndr, ov, okk);
    read_slot(2, 1'b1, v, kk);
    n_cmp++; if (v !== 1'b1) begin n_fail++; $display("FAIL known_valid: got %b want 1", v); end
    n_cmp++; if (kk[6*64 +: 64] !== 64'ha9301f10fb4d4d71) begin n_fail++; $display("FAIL known_round6: got %h want a9301f10fb4d4d71", kk[6*64 +: 64]); end
    n_cmp++; if (kk !== ref_kk(64'haf361916fd4b4b77)) begin n_fail++; $display("FAIL known_kk: got %h want %h", kk, ref_kk(64'haf361916fd4b4b77)); end
    read_slot(2, 1'b0, v, kk);
    n_cmp++; if (v !== 1'b0) begin n_fail++; $display("FAIL known_even_valid: got %b want 0", v); end
  endtask

  // Rejected starts during RUN and WRITE, then a start accepted right after WRITE.
  task automatic test_drop();
    logic [63:0] ck1, ck2, ck3;
    logic v;
    logic [447:0] kk;
    int ndone;
    bit exp_drop, exp_done;
    ck1 = {$urandom, $urandom}; ck2 = {$urandom, $urandom}; ck3 = {$urandom, $urandom};
    ndone = 0;
    i_ck = ck1; i_chan = 2'd1; i_parity = 1'b0; start = 1'b1;
    tick();
    for (int k = 1; k <= 19; k++) begin
      exp_drop = (k == 4) || (k == 9);
      exp_done = (k == 8) || (k == 17);
      n_cmp++; if (drop !== exp_drop) begin n_fail++; $display("FAIL drop_k%0d: got %b want %b", k, drop, exp_drop); end
      n_cmp++; if (done !== exp_done) begin n_fail++; $display("FAIL drop_done_k%0d: got %b want %b", k, done, exp_done); end
      if (done) ndone++;
      start = 1'b0;
      if (k == 3 || k == 8) begin start = 1'b1; i_ck = ck2; i_chan = 2'd3; i_parity = 1'b1; end
      if (k == 9) begin start = 1'b1; i_ck = ck3; i_chan = 2'd0; i_parity = 1'b1; end
      tick();
    end
    start = 1'b0;
    n_cmp++; if (ndone != 2) begin n_fail++; $display("FAIL drop_done_count: got %0d want 2", ndone); end
    mdl_kk[2] = ref_kk(ck1); mdl_valid[2] = 1'b1;
    mdl_kk[1] = ref_kk(ck3); mdl_valid[1] = 1'b1;
    read_slot(1, 1'b0, v, kk);
    n_cmp++; if (v !== 1'b1 || kk !== mdl_kk[2]) begin n_fail++; $display("FAIL drop_first_slot: got %b/%h want 1/%h", v, kk, mdl_kk[2]); end
    read_slot(0, 1'b1, v, kk);
    n_cmp++; if (v !== 1'b1 || kk !== mdl_kk[1]) begin n_fail++; $display("FAIL drop_b2b_slot: got %b/%h want 1/%h", v, kk, mdl_kk[1]); end
    read_slot(3, 1'b1, v, kk);
    n_cmp++; if (v !== mdl_valid[7]) begin n_fail++; $display("FAIL drop_ignored_slot: got %b want %b", v, mdl_valid[7]); end
  endtask

  task automatic test_invalidate();
    int nb, nd, da, ndr;
    logic ov, v;
    logic [447:0] okk, kk;
    logic [63:0] cka, ckb;
    cka = {$urandom, $urandom}; ckb = {$urandom, $urandom};
    run_load(cka, 1, 1'b0, 0, nb, nd, da, ndr, ov, okk);
    run_load(ckb, 1, 1'b1, 0, nb, nd, da, ndr, ov, okk);
    i_inv = 1'b1; i_inv_chan = 2'd1; i_inv_parity = 1'b0;
    tick();
    i_inv = 1'b0;
    mdl_valid[2] = 1'b0;
    read_slot(1, 1'b0, v, kk);
    n_cmp++; if (v !== 1'b0) begin n_fail++; $display("FAIL inv_even_valid: got %b want 0", v); end
    read_slot(1, 1'b1, v, kk);
    n_cmp++; if (v !== 1'b1) begin n_fail++; $display("FAIL inv_odd_valid: got %b want 1", v); end
    n_cmp++; if (kk !== ref_kk(ckb)) begin n_fail++; $display("FAIL inv_odd_kk: got %h want %h", kk, ref_kk(ckb)); end
  endtask

  task automatic test_inv_vs_write();
    int nb, nd, da, ndr;
    logic ov, v;
    logic [447:0] okk, kk;
    logic [63:0] ckc, ckd;
    ckc = {$urandom, $urandom}; ckd = {$urandom, $urandom};
    run_load(ckc, 2, 1'b0, 8, nb, nd, da, ndr, ov, okk);
    read_slot(2, 1'b0, v, kk);
    n_cmp++; if (v !== 1'b1 || kk !== ref_kk(ckc)) begin n_fail++; $display("FAIL invwr_write_wins: got %b/%h want 1/%h", v, kk, ref_kk(ckc)); end
    run_load(ckd, 2, 1'b0, 3, nb, nd, da, ndr, ov, okk);
    n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL invwr_run_cleared: got %b want 0", ov); end
    read_slot(2, 1'b0, v, kk);
    n_cmp++; if (v !== 1'b1 || kk !== ref_kk(ckd)) begin n_fail++; $display("FAIL invwr_run_rewrite: got %b/%h want 1/%h", v, kk, ref_kk(ckd)); end
  endtask

  task automatic test_random();
    int nb, nd, da, ndr, ch, sel, ik, slot;
    bit par, exp_old_v;
    logic ov, v;
    logic [447:0] okk, kk, exp_old_kk;
    logic [63:0] ck;
    for (int it = 0; it < 10; it++) begin
      ck  = {$urandom, $urandom};
      ch  = $urandom_range(0, 3);
      par = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 2);
      ik  = (sel == 0) ? 0 : ((sel == 1) ? 3 : 8);
      slot = ch * 2 + int'(par);
      exp_old_v  = (ik == 3) ? 1'b0 : mdl_valid[slot];
      exp_old_kk = mdl_kk[slot];
      run_load(ck, ch, par, ik, nb, nd, da, ndr, ov, okk);
      n_cmp++; if (nb != 8 || da != 8) begin n_fail++; $display("FAIL rnd%0d_timing: busy %0d done_at %0d want 8/8", it, nb, da); end
      n_cmp++; if (ov !== exp_old_v) begin n_fail++; $display("FAIL rnd%0d_old_valid: got %b want %b", it, ov, exp_old_v); end
      if (exp_old_v) begin
        n_cmp++; if (okk !== exp_old_kk) begin n_fail++; $display("FAIL rnd%0d_old_kk: got %h want %h", it, okk, exp_old_kk); end
      end
      read_slot(ch, par, v, kk);
      n_cmp++; if (v !== 1'b1 || kk !== mdl_kk[slot]) begin n_fail++; $display("FAIL rnd%0d_new: got %b/%h want 1/%h", it, v, kk, mdl_kk[slot]); end
      if ($urandom_range(0, 1) == 1) begin
        i_inv = 1'b1; i_inv_chan = 2'($urandom_range(0, 3)); i_inv_parity = 1'($urandom_range(0, 1));
        mdl_valid[int'(i_inv_chan) * 2 + int'(i_inv_parity)] = 1'b0;
        tick();
        i_inv = 1'b0;
      end
      ch = $urandom_range(0, 3); par = 1'($urandom_range(0, 1)); slot = ch * 2 + int'(par);
      read_slot(ch, par, v, kk);
      n_cmp++; if (v !== mdl_valid[slot]) begin n_fail++; $display("FAIL rnd%0d_probe_valid: got %b want %b", it, v, mdl_valid[slot]); end
      if (mdl_valid[slot]) begin
        n_cmp++; if (kk !== mdl_kk[slot]) begin n_fail++; $display("FAIL rnd%0d_probe_kk: got %h want %h", it, kk, mdl_kk[slot]); end
      end
    end
  endtask

  // The CHANNELS=3 instance shares all inputs; channel 3 does not exist there.
  task automatic test_out_of_range();
    logic v;
    logic [447:0] kk;
    read_slot(3, 1'b0, v, kk);
    n_cmp++; if (o_valid3 !== 1'b0 || o_kk3 !== 448'd0) begin n_fail++; $display("FAIL oor_read: got %b/%h want 0/0", o_valid3, o_kk3); end
    i_inv = 1'b1; i_inv_chan = 2'd3; i_inv_parity = 1'b0;
    tick();
    i_inv = 1'b0;
    mdl_valid[6] = 1'b0;
    read_slot(2, 1'b1, v, kk);
    n_cmp++; if (o_valid3 !== mdl_valid[5]) begin n_fail++; $display("FAIL oor_inv_noeffect: got %b want %b", o_valid3, mdl_valid[5]); end
    if (mdl_valid[5]) begin
      n_cmp++; if (o_kk3 !== mdl_kk[5]) begin n_fail++; $display("FAIL oor_kk3: got %h want %h", o_kk3, mdl_kk[5]); end
    end
    i_ck = {$urandom, $urandom}; i_chan = 2'd3; i_parity = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (drop3 !== 1'b1 || busy3 !== 1'b0) begin n_fail++; $display("FAIL oor_start: drop %b busy %b want 1/0", drop3, busy3); end
    n_cmp++; if (busy !== 1'b1 || drop !== 1'b0) begin n_fail++; $display("FAIL oor_start_4ch: busy %b drop %b want 1/0", busy, drop); end
    tick();
    n_cmp++; if (busy3 !== 1'b0 || drop3 !== 1'b0) begin n_fail++; $display("FAIL oor_after: busy %b drop %b want 0/0", busy3, drop3); end
    mdl_kk[6] = ref_kk(i_ck); mdl_valid[6] = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    read_slot(3, 1'b0, v, kk);
    n_cmp++; if (v !== 1'b1 || kk !== mdl_kk[6]) begin n_fail++; $display("FAIL oor_4ch_slot: got %b/%h want 1/%h", v, kk, mdl_kk[6]); end
  endtask

  task automatic test_reset_abort();
    logic v;
    logic [447:0] kk;
    int ndone;
    ndone = 0;
    i_ck = {$urandom, $urandom}; i_chan = 2'd0; i_parity = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int s = 0; s < 8; s++) mdl_valid[s] = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_state: busy %b done %b want 0/0", busy, done); end
    for (int k = 0; k < 8; k++) begin
      if (done) ndone++;
      tick();
    end
    n_cmp++; if (ndone != 0) begin n_fail++; $display("FAIL abort_done: got %0d want 0", ndone); end
    for (int s = 0; s < 8; s++) begin
      read_slot(s / 2, 1'(s % 2), v, kk);
      n_cmp++; if (v !== mdl_valid[s]) begin n_fail++; $display("FAIL abort_valid_slot%0d: got %b want %b", s, v, mdl_valid[s]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; i_ck = '0; i_chan = '0; i_parity = 1'b0;
    i_inv = 1'b0; i_inv_chan = '0; i_inv_parity = 1'b0; rd_chan = '0; rd_parity = 1'b0;
    for (int s = 0; s < 8; s++) begin mdl_kk[s] = '0; mdl_valid[s] = 1'b0; end
    test_reset();
    test_zero_key();
    test_known_key();
    test_drop();
    test_invalidate();
    test_inv_vs_write();
    test_random();
    test_out_of_range();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_key_bank.md
Name: csa_key_bank

Overview:
- Multi-channel successor to the single-key CSA key schedule.
- Accepts a 64-bit control word (CK) per channel and parity (even/odd), and expands it iteratively, one round per cycle, into the 56-byte block-cipher schedule (KK).
- Stores each expanded schedule in a bank of CHANNELS×2 slots.
- Provides a registered read port, so the descrambler datapath can fetch the KK for any channel/parity while a new key is being expanded.

Parameters:
- CHANNELS, 4, number of independent key channels; legal 1..16.
- CHW, $clog2(CHANNELS) (min 1), channel index width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to expand i_ck into slot {i_chan,i_parity}
- i_ck  in  64  control word, bit 63 = first CK byte MSB
- i_chan  in  CHW  target channel for start
- i_parity  in  1  target parity for start: 0 even, 1 odd
- i_inv  in  1  one-cycle request to invalidate slot {i_inv_chan,i_inv_parity}
- i_inv_chan  in  CHW  invalidate channel
- i_inv_parity  in  1  invalidate parity
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse: slot written
- drop  out  1  one-cycle pulse: start ignored
- rd_chan  in  CHW  read channel
- rd_parity  in  1  read parity
- o_kk  out  448  KK of read slot; round r occupies [r*64+:64]
- o_valid  out  1  read slot holds a valid schedule

Behaviour:
- Reset:
  - busy, done, drop, o_valid = 0; o_kk = 0.
  - All slot valid bits cleared.
  - FSM returns to IDLE.
  - An expansion in progress is aborted with no bank write and no done pulse.
- FSM states: IDLE, RUN, WRITE.
  - IDLE: start=1 latches i_ck into kb register, latches {i_chan,i_parity} as the target slot, loads round counter = 6, goes to RUN.
  - RUN: each cycle writes shadow round r = kb XOR {8{r[7:0]}}, then kb <= PERM(kb) and r <= r-1. The cycle that writes r=0 goes to WRITE.
  - WRITE: copies the shadow into the target slot, sets its valid bit, and pulses done. Next state is IDLE.
- Round schedule: kb for round 6 = CK; kb(r-1) = PERM(kb(r)). PERM is the fixed 64-bit CSA key bit permutation.
- Latency:
  - start sampled at edge T.
  - busy = 1 from T+1 through the WRITE cycle (8 cycles: 7 RUN + 1 WRITE).
  - done = 1 in the WRITE cycle.
  - The slot is updated at the end of the WRITE cycle.
  - Earliest new start is accepted in the cycle after WRITE.
- start while busy=1 (including the WRITE cycle): the request is ignored, drop pulses in the following cycle, and the bank is unchanged.
- i_inv clears the slot's valid bit at the next edge in any state. KK contents are untouched.
- Invalidate vs. write to the same slot:
  - If i_inv targets the slot being written in the WRITE cycle, the write wins and valid = 1.
  - If i_inv targets the in-progress target during RUN, the slot is cleared now and set again by the later WRITE.
- Read port: o_kk and o_valid are registered, 1 cycle after rd_chan/rd_parity.
  - A read of the target slot returns the old contents until the WRITE edge.
  - A read issued in the cycle after done returns the new KK.
- Out-of-range indices when CHANNELS is not a power of two:
  - rd_chan ≥ CHANNELS gives o_valid = 0, o_kk = 0.
  - start with i_chan ≥ CHANNELS is ignored with a drop pulse.
  - i_inv with out-of-range channel has no effect.
- The expansion datapath is independent of the bank. The bank has 1 write port and 1 read port, with no bypass.

Decomposition:
- Package csa_pkg:
  - CSA_KK_ROUNDS = 7; CK_W = 64; KK_W = 448.
  - The 64-entry key-bit permutation table.
  - A function csa_key_perm(64-bit) → 64-bit.
  - FSM state enum for csa_key_bank.
- Sub-module csa_key_round: combinational, kb in, round index in → round KK word and PERM(kb).
- csa_key_bank contains the FSM, the counter, the shadow and the slot bank.

Test Plan:
1. Reset, then start ck=64'h0, chan 0, even → busy for 8 cycles, done at T+8; read {0,0} → o_valid=1, o_kk round r = 64'h0r0r0r0r0r0r0r0r (r=0..6, e.g. round 6 = 64'h0606060606060606).
2. start ck=64'haf361916fd4b4b77, chan 2, odd → o_kk[6*64+:64] = 64'haf361916fd4b4b77 ^ 64'h0606060606060606 = 64'ha9301f10fb4d4d71; the full 448 bits match the csa_pkg golden function; the even slot of chan 2 stays o_valid=0.
3. Second start at T+3 during RUN → drop pulses at T+4; exactly one done; bank holds the first CK only.
4. Load chan 1 even and odd with different CKs, then i_inv chan 1 even → even o_valid=0, odd o_valid=1 with unchanged KK.
5. i_inv on the target slot coincident with WRITE → o_valid=1 with the new KK; rst asserted at RUN cycle 4 → busy=0 next cycle, no done, all o_valid=0.
6. CHANNELS=3 build: rd_chan=3 → o_valid=0, o_kk=0; start i_chan=3 → drop=1, busy stays 0.
